// File: rtl/fell_mon_pkg.sv
// Shared types and default sizing for the falling-edge monitor.
package fell_mon_pkg;

  localparam int FELL_CNT_W  = 16;
  localparam int FELL_GAP_W  = 8;
  localparam int FELL_PERIOD = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2
  } fell_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load (clear > load > inc).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fell_monitor.sv
// Registered 1->0 detector with event count, fall-to-fall spacing and period check.
//   state | meaning
//   IDLE  | disabled; gap counter held at 0, a_q still follows a
//   ARM   | waiting for the first fall; no spacing check yet
//   TRACK | gap counter running; each fall is checked against PERIOD
module fell_monitor
  import fell_mon_pkg::*;
#(
  parameter int CNT_W  = FELL_CNT_W,
  parameter int GAP_W  = FELL_GAP_W,
  parameter int PERIOD = FELL_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             clr,
  output logic             fell_pulse,
  output logic [CNT_W-1:0] fell_count,
  output logic [GAP_W-1:0] last_gap,
  output logic             period_err,
  output logic [CNT_W-1:0] err_count,
  output logic             sticky_err
);

  localparam logic [GAP_W-1:0] PERIOD_G = GAP_W'(PERIOD);

  fell_state_e      state, state_nxt;
  logic             a_q;
  logic             fall;
  logic             fall_acc;
  logic             track_fall;
  logic             err_hit;
  logic             gap_clr;
  logic             gap_load;
  logic             gap_inc;
  logic [GAP_W-1:0] gap_cnt;

  assign fall = a_q & ~a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // en=0 wins over clr and fall; clr wins over fall.
  always_comb begin
    state_nxt  = state;
    fall_acc   = 1'b0;
    track_fall = 1'b0;
    err_hit    = 1'b0;
    gap_clr    = 1'b0;
    gap_load   = 1'b0;
    gap_inc    = 1'b0;
    case (state)
      IDLE: begin
        gap_clr = 1'b1;
        if (en) state_nxt = ARM;
      end
      ARM: begin
        if (!en) begin
          state_nxt = IDLE;
          gap_clr   = 1'b1;
        end else if (clr) begin
          gap_clr = 1'b1;
        end else if (fall) begin
          fall_acc  = 1'b1;
          gap_load  = 1'b1;
          state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (!en) begin
          state_nxt = IDLE;
          gap_clr   = 1'b1;
        end else if (clr) begin
          gap_clr   = 1'b1;
          state_nxt = ARM;
        end else if (fall) begin
          fall_acc   = 1'b1;
          track_fall = 1'b1;
          gap_load   = 1'b1;
          err_hit    = (gap_cnt != PERIOD_G);
        end else begin
          gap_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gap_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= 1'b0;
      fell_pulse <= 1'b0;
      period_err <= 1'b0;
      sticky_err <= 1'b0;
      last_gap   <= '0;
    end else begin
      a_q        <= a;
      fell_pulse <= fall_acc;
      period_err <= err_hit;
      if (clr) begin
        sticky_err <= 1'b0;
        last_gap   <= '0;
      end else begin
        if (err_hit)    sticky_err <= 1'b1;
        if (track_fall) last_gap   <= gap_cnt;
      end
    end
  end

  sat_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (gap_clr),
    .load     (gap_load),
    .load_val (GAP_W'(1)),
    .inc      (gap_inc),
    .count    (gap_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fell_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (fall_acc),
    .count    (fell_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (err_hit),
    .count    (err_count)
  );

endmodule
